// File: rtl/des_perm_pipe.sv
// des_perm_pipe: pipelined DES IP/FP bit permutation over LANES 64-bit blocks,
// valid/ready handshake with bubble-collapsing stalls and a sideband tag.
module des_perm_pipe #(
    parameter int unsigned LANES      = 1,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [64*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_mode,
    output logic                  busy
);

    localparam int unsigned DW   = 64 * LANES;
    localparam int unsigned LAST = PIPE_DEPTH - 1;

    logic [DW-1:0] ip_c;
    logic [DW-1:0] fp_c;
    logic [DW-1:0] perm_c;

    // IP wiring: output DES bit i takes input bit SRC; FP is the inverse mapping.
    // DES bit n lives at index 64-n within its lane.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar i = 1; i <= 64; i++) begin : g_bit
            localparam int R   = (i - 1) / 8;
            localparam int C   = (i - 1) % 8;
            localparam int SRC = ((R < 4) ? (58 + 2 * R) : (49 + 2 * R)) - 8 * C;
            assign ip_c[64*l + 64 - i]   = in_data[64*l + 64 - SRC];
            assign fp_c[64*l + 64 - SRC] = in_data[64*l + 64 - i];
        end
    end

    assign perm_c = in_mode ? fp_c : ip_c;

    logic [PIPE_DEPTH-1:0] v_q, v_d;
    logic [PIPE_DEPTH-1:0] load_c;
    logic                  full_tail_c;
    logic                  mode_q [PIPE_DEPTH];
    logic                  mode_d [PIPE_DEPTH];
    logic [TAG_W-1:0]      tag_q  [PIPE_DEPTH];
    logic [TAG_W-1:0]      tag_d  [PIPE_DEPTH];
    logic [DW-1:0]         data_q [PIPE_DEPTH];
    logic [DW-1:0]         data_d [PIPE_DEPTH];

    // Stage k may load unless it and every stage after it are full while stalled.
    always_comb begin
        full_tail_c = 1'b1;
        load_c      = '0;
        for (int k = int'(LAST); k >= 0; k--) begin
            full_tail_c = full_tail_c & v_q[k];
            load_c[k]   = out_ready | ~full_tail_c;
        end
    end

    assign in_ready = load_c[0] & ~rst;

    // Next-state: each loading stage takes its predecessor; payload only moves with a valid beat.
    always_comb begin
        v_d    = v_q;
        mode_d = mode_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (load_c[0]) begin
            v_d[0] = in_valid & in_ready;
            if (in_valid) begin
                mode_d[0] = in_mode;
                tag_d[0]  = in_tag;
                data_d[0] = perm_c;
            end
        end
        for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
            if (load_c[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    mode_d[k] = mode_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                mode_q[k] <= 1'b0;
                tag_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            mode_q <= mode_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_tag   = tag_q[LAST];
    assign out_mode  = mode_q[LAST];
    assign busy      = |v_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Self-checking bench for des_perm_pipe: vector table, randomized round trip,
// backpressure, bubbles and mid-flight reset against a table-based reference.
module tb_des_perm_pipe;

    localparam int PD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
    logic [63:0] in_data, out_data;
    logic [3:0]  in_tag, out_tag;

    logic         in4_valid, in4_mode;
    logic [255:0] in4_data;
    logic [3:0]   in4_tag;
    logic         a_in_ready, a_out_valid, a_out_mode, a_busy;
    logic [255:0] a_out_data;
    logic [3:0]   a_out_tag;
    logic         b_in_ready, b_out_valid, b_out_mode, b_busy;
    logic [255:0] b_out_data;
    logic [3:0]   b_out_tag;

    always #5 clk = ~clk;

    des_perm_pipe #(.LANES(1), .PIPE_DEPTH(PD), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_mode(out_mode), .busy(busy));

    des_perm_pipe #(.LANES(4), .PIPE_DEPTH(1), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(a_in_ready), .in_mode(in4_mode),
        .in_data(in4_data), .in_tag(in4_tag), .out_valid(a_out_valid), .out_ready(1'b1),
        .out_data(a_out_data), .out_tag(a_out_tag), .out_mode(a_out_mode), .busy(a_busy));

    des_perm_pipe #(.LANES(4), .PIPE_DEPTH(4), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(b_in_ready), .in_mode(in4_mode),
        .in_data(in4_data), .in_tag(in4_tag), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_data(b_out_data), .out_tag(b_out_tag), .out_mode(b_out_mode), .busy(b_busy));

    int ip_tab [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                        57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_tab [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                        34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        logic        mode;
    } beat_t;

    typedef struct {
        logic        mode;
        logic [63:0] data;
        logic [3:0]  tag;
        logic [63:0] exp;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    int          n_out   = 0;
    beat_t       exp_q[$];
    logic [63:0] cap_q[$];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [3:0]  prev_tag;
    logic        prev_mode;

    function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic m);
        logic [63:0] r;
        int src;
        r = '0;
        for (int j = 1; j <= 64; j++) begin
            src = m ? fp_tab[j-1] : ip_tab[j-1];
            r[64-j] = x[64-src];
        end
        return r;
    endfunction

    function automatic logic [255:0] ref_lanes(input logic [255:0] x, input logic m);
        logic [255:0] r;
        for (int l = 0; l < 4; l++) r[64*l +: 64] = ref_perm(x[64*l +: 64], m);
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle on the main DUT: inputs already driven at the negedge.
    task automatic cycle();
        beat_t b;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 256'(out_valid), 256'(1));
            chk("stall_data", 256'(out_data), 256'(prev_data));
            chk("stall_tag", 256'(out_tag), 256'(prev_tag));
            chk("stall_mode", 256'(out_mode), 256'(prev_mode));
        end
        chk("in_ready", 256'(in_ready), 256'(!rst && (out_ready || exp_q.size() < PD)));
        chk("busy", 256'(busy), 256'(exp_q.size() != 0));
        if (out_valid && exp_q.size() == 0) chk("unexpected_beat", 256'(out_valid), 256'(0));
        if (!rst && out_valid && out_ready && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("out_data", 256'(out_data), 256'(b.data));
            chk("out_tag", 256'(out_tag), 256'(b.tag));
            chk("out_mode", 256'(out_mode), 256'(b.mode));
            cap_q.push_back(out_data);
            n_out++;
        end
        if (!rst && in_valid && in_ready) begin
            b.data = ref_perm(in_data, in_mode);
            b.tag  = in_tag;
            b.mode = in_mode;
            exp_q.push_back(b);
            n_acc++;
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;
        prev_mode  = out_mode;
        if (rst) exp_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        in_valid  = 1'b1;
        in_mode   = v.mode;
        in_data   = v.data;
        in_tag    = v.tag;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            cycle();
            lat++;
        end
        chk("vec_latency", 256'(lat), 256'(PD));
        chk("vec_data", 256'(out_data), 256'(v.exp));
        chk("vec_tag", 256'(out_tag), 256'(v.tag));
        cycle();
    endtask

    // Random stream: in_valid and out_ready toggle randomly until all beats drain.
    task automatic run_stream(input logic m, input int nbeats);
        logic [63:0] src[$];
        int base, guard;
        src = cap_q;
        if (m == 1'b0) begin
            src.delete();
            for (int i = 0; i < nbeats; i++) src.push_back({$urandom, $urandom});
        end
        cap_q.delete();
        base  = n_acc;
        guard = 0;
        while (((n_acc - base) < nbeats || exp_q.size() != 0) && guard < 20000) begin
            in_valid  = ((n_acc - base) < nbeats) && ($urandom_range(3) != 0);
            in_mode   = m;
            in_data   = ((n_acc - base) < nbeats) ? src[n_acc - base] : 64'h0;
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            cycle();
            guard++;
        end
        in_valid = 1'b0;
        chk("stream_done", 256'(guard < 20000), 256'(1));
    endtask

    vec_t        vecs[6];
    logic [63:0] orig[$];
    int          lat_a, lat_b;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mode: 1'b0, data: 64'h0123456789ABCDEF, tag: 4'h1, exp: 64'hCC00CCFFF0AAF0AA};
        vecs[1] = '{mode: 1'b1, data: 64'h8000000000000000, tag: 4'h2, exp: 64'h0000000000000040};
        vecs[2] = '{mode: 1'b0, data: 64'h8000000000000000, tag: 4'h3, exp: 64'h0000000001000000};
        vecs[3] = '{mode: 1'b1, data: 64'hCC00CCFFF0AAF0AA, tag: 4'h4, exp: 64'h0123456789ABCDEF};
        vecs[4] = '{mode: 1'b0, data: 64'h0000000000000000, tag: 4'h5, exp: 64'h0000000000000000};
        vecs[5] = '{mode: 1'b1, data: 64'hFFFFFFFFFFFFFFFF, tag: 4'hF, exp: 64'hFFFFFFFFFFFFFFFF};

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
        in4_valid = 1'b0; in4_mode = 1'b0; in4_data = '0; in4_tag = '0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_out_tag", 256'(out_tag), 256'(0));
        chk("rst_out_mode", 256'(out_mode), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Known-answer vectors with latency measurement
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Round trip: IP then FP of the IP outputs must restore the originals
        run_stream(1'b0, 1000);
        orig.delete();
        foreach (exp_q[i]) orig.push_back(exp_q[i].data);
        orig = cap_q;
        for (int i = 0; i < orig.size(); i++) orig[i] = ref_perm(orig[i], 1'b1);
        run_stream(1'b1, 1000);
        chk("rt_count", 256'(cap_q.size()), 256'(1000));
        for (int i = 0; i < cap_q.size() && i < orig.size(); i++)
            chk("rt_data", 256'(cap_q[i]), 256'(orig[i]));

        // Backpressure: 10 beats with a 5-cycle out_ready stall mid-stream
        n_out = 0;
        begin
            int base;
            base = n_acc;
            for (int c = 0; c < 60 && ((n_acc - base) < 10 || exp_q.size() != 0); c++) begin
                in_valid  = (n_acc - base) < 10;
                in_mode   = c[0];
                in_data   = {$urandom, $urandom};
                in_tag    = 4'(c);
                out_ready = !(c >= 3 && c < 8);
                cycle();
            end
        end
        in_valid = 1'b0;
        chk("t4_count", 256'(n_out), 256'(10));

        // Bubbles: 1,0,1,0 with out_ready low fills both stages, then input is blocked
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c % 2 == 0);
            in_mode  = 1'b0;
            in_data  = {$urandom, $urandom};
            in_tag   = 4'(8 + c);
            cycle();
        end
        in_valid = 1'b1;
        #1;
        chk("t5_out_valid", 256'(out_valid), 256'(1));
        chk("t5_in_ready_full", 256'(in_ready), 256'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("t5_drained", 256'(exp_q.size()), 256'(0));

        // Reset with PIPE_DEPTH beats in flight
        out_ready = 1'b0;
        for (int c = 0; c < PD; c++) begin
            in_valid = 1'b1;
            in_mode  = 1'b1;
            in_data  = {$urandom, $urandom};
            in_tag   = 4'hA;
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("t6_out_valid", 256'(out_valid), 256'(0));
        chk("t6_busy", 256'(busy), 256'(0));
        chk("t6_out_data", 256'(out_data), 256'(0));
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = 64'h0123456789ABCDEF;
        in_tag    = 4'h6;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_out = 0;
        repeat (8) cycle();
        chk("t6_one_beat", 256'(n_out), 256'(1));
        prev_stall = 1'b0;

        // Four-lane instances at PIPE_DEPTH 1 and 4
        in4_valid = 1'b1;
        in4_mode  = 1'b0;
        in4_data  = {64'h0000000000000000, 64'hCC00CCFFF0AAF0AA, 64'h8000000000000000, 64'h0123456789ABCDEF};
        in4_tag   = 4'h9;
        #1;
        chk("l4a_in_ready", 256'(a_in_ready), 256'(1));
        chk("l4b_in_ready", 256'(b_in_ready), 256'(1));
        @(posedge clk);
        @(negedge clk);
        in4_valid = 1'b0;
        lat_a = 0;
        lat_b = 0;
        for (int c = 1; c <= 10; c++) begin
            if (a_out_valid && lat_a == 0) begin
                lat_a = c;
                chk("l4a_data", a_out_data, ref_lanes(in4_data, 1'b0));
                chk("l4a_lane0", 256'(a_out_data[63:0]), 256'(64'hCC00CCFFF0AAF0AA));
                chk("l4a_tag", 256'(a_out_tag), 256'(4'h9));
            end
            if (b_out_valid && lat_b == 0) begin
                lat_b = c;
                chk("l4b_data", b_out_data, ref_lanes(in4_data, 1'b0));
                chk("l4b_lane1", 256'(b_out_data[127:64]), 256'(64'h0000000001000000));
                chk("l4b_tag", 256'(b_out_tag), 256'(4'h9));
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("l4a_latency", 256'(lat_a), 256'(1));
        chk("l4b_latency", 256'(lat_b), 256'(4));
        chk("l4_idle", 256'({a_busy, b_busy}), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
